// File: rtl/audio_i2s_clock_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_i2s_clock_tx : I2S bit clock / word select / serial data generator    |
// |                      for a 16+16-bit stereo DAC, plus a tempo square wave.   |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module audio_i2s_clock_tx #(
  parameter int MASTER_FREQ   = 100_000_000,
  parameter int BCLK_HALF_DIV = 32,
  parameter int TEMPO_FREQ    = 4,
  parameter int TEMPO_BITS    = 26
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] InputData,
  output logic        SyncCLK,
  output logic        I2S_CLK,
  output logic        I2S_WS,
  output logic        I2S_DATA,
  output logic        Tempo_CLK
);

  localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int TEMPO_HALF = MASTER_FREQ / (2 * TEMPO_FREQ);

  localparam logic [DIV_W-1:0]      c_divLast   = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [TEMPO_BITS-1:0] c_tempoLast = TEMPO_BITS'(TEMPO_HALF - 1);

  logic [DIV_W-1:0]      r_divCnt;
  logic                  r_bitClk;
  logic [4:0]            r_slot;
  logic [31:0]           r_frame;
  logic                  r_prevRight0;
  logic                  r_ws;
  logic                  r_data;
  logic                  r_sync;
  logic [TEMPO_BITS-1:0] r_tempoCnt;
  logic                  r_tempoClk;

  logic       w_divTerm;
  logic       w_fallEvt;
  logic [4:0] w_nextSlot;
  logic [4:0] w_bitIdx;
  logic       w_nextData;

  assign w_divTerm  = (r_divCnt == c_divLast);
  assign w_fallEvt  = w_divTerm & r_bitClk;
  assign w_nextSlot = r_slot + 5'd1;
  // Slot n (1..31) carries frame bit 32-n: left[15] at slot 1 down to right[1] at slot 31.
  assign w_bitIdx   = 5'(6'd32 - {1'b0, w_nextSlot});

  always_comb begin
    w_nextData = 1'b0;
    if (w_nextSlot == 5'd0) begin
      w_nextData = r_frame[0];
    end else begin
      w_nextData = r_frame[w_bitIdx];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_divCnt <= '0;
      r_bitClk <= 1'b0;
    end else if (w_divTerm) begin
      r_divCnt <= '0;
      r_bitClk <= ~r_bitClk;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_slot       <= 5'd31;
      r_frame      <= '0;
      r_prevRight0 <= 1'b0;
      r_ws         <= 1'b0;
      r_data       <= 1'b0;
      r_sync       <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      if (w_fallEvt) begin
        r_slot <= w_nextSlot;
        r_ws   <= w_nextSlot[4];
        r_data <= w_nextData;
        if (w_nextSlot == 5'd0) begin
          r_frame      <= InputData;
          r_prevRight0 <= r_frame[0];
          r_sync       <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_tempoCnt <= '0;
      r_tempoClk <= 1'b0;
    end else if (r_tempoCnt == c_tempoLast) begin
      r_tempoCnt <= '0;
      r_tempoClk <= ~r_tempoClk;
    end else begin
      r_tempoCnt <= r_tempoCnt + TEMPO_BITS'(1);
    end
  end

  assign SyncCLK   = r_sync;
  assign I2S_CLK   = r_bitClk;
  assign I2S_WS    = r_ws;
  assign I2S_DATA  = r_data;
  assign Tempo_CLK = r_tempoClk;

  // The hold mirrors what was driven at slot 0; kept so the bit survives frame reuse.
  logic w_unusedHold;
  assign w_unusedHold = r_prevRight0;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_clock_tx.sv
`default_nettype none
// Directed bench for audio_i2s_clock_tx with BCLK_HALF_DIV=2, tempo half period 10.
module tb_audio_i2s_clock_tx;

  logic        CLK;
  logic        Reset;
  logic [31:0] InputData;
  logic        SyncCLK;
  logic        I2S_CLK;
  logic        I2S_WS;
  logic        I2S_DATA;
  logic        Tempo_CLK;

  int nChk;
  int nFail;
  int k;

  audio_i2s_clock_tx #(
    .MASTER_FREQ  (1000),
    .BCLK_HALF_DIV(2),
    .TEMPO_FREQ   (50),
    .TEMPO_BITS   (8)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .InputData(InputData),
    .SyncCLK  (SyncCLK),
    .I2S_CLK  (I2S_CLK),
    .I2S_WS   (I2S_WS),
    .I2S_DATA (I2S_DATA),
    .Tempo_CLK(Tempo_CLK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s (k=%0d): observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, ".sync"}, SyncCLK, 1'b0);
    chk({tag, ".bclk"}, I2S_CLK, 1'b0);
    chk({tag, ".ws"}, I2S_WS, 1'b0);
    chk({tag, ".data"}, I2S_DATA, 1'b0);
    chk({tag, ".tempo"}, Tempo_CLK, 1'b0);
  endtask

  // One CLK cycle; k counts posedges since reset release.
  // Rise at k=2, fall at k=4 (period 4); slot s of frame f begins at k=4+128f+4s.
  task automatic tick();
    logic expSync;
    @(posedge CLK);
    #1;
    k++;
    expSync = (k >= 4) && (k % 4 == 0) && (((k / 4) - 1) % 32 == 0);
    chk("bclk", I2S_CLK, logic'((k >> 1) & 1));
    chk("tempo", Tempo_CLK, logic'((k / 10) % 2));
    chk("sync", SyncCLK, expSync);
  endtask

  // seq[31-s] is the hand-written expected I2S_DATA bit of slot s.
  task automatic chkSlots(input int f, input int s0, input int s1,
                          input logic [31:0] seq, input string tag);
    for (int s = s0; s <= s1; s++) begin
      while (k < 4 + 128 * f + 4 * s) tick();
      chk({tag, ".data"}, I2S_DATA, seq[31-s]);
      chk({tag, ".ws"}, I2S_WS, logic'(s >= 16));
    end
  endtask

  initial begin
    nChk      = 0;
    nFail     = 0;
    k         = 0;
    Reset     = 1'b0;
    InputData = 32'hA5C3_0F01;

    // Test 1: outputs held at zero in reset, then release
    repeat (3) begin
      @(posedge CLK);
      #1;
      chkZero("rst1");
    end
    @(negedge CLK);
    Reset = 1'b1;
    k = 0;
    repeat (3) tick();

    // Tests 2/3: first frame after reset, slot 0 is zero
    chkSlots(0, 0, 31, {1'b0, 16'hA5C3, 15'b000011110000000}, "f0");

    // Test 4: slot 0 carries old right[0]; mid-frame change ignored
    chkSlots(1, 0, 4, {1'b1, 16'hA5C3, 15'b000011110000000}, "f1a");
    InputData = 32'hFFFF_FFFF;
    chkSlots(1, 5, 31, {1'b1, 16'hA5C3, 15'b000011110000000}, "f1b");
    chkSlots(2, 0, 31, 32'hFFFF_FFFF, "f2");

    // Test 5: asynchronous reset in slot 20
    chkSlots(3, 0, 20, 32'hFFFF_FFFF, "f3");
    #2;
    Reset = 1'b0;
    #1;
    chkZero("rstMid");
    InputData = 32'h8000_7FFF;
    repeat (2) begin
      @(posedge CLK);
      #1;
      chkZero("rst2");
    end
    @(negedge CLK);
    Reset = 1'b1;
    k = 0;

    // Test 6: restart timing, slot 0 zero despite previous all-ones frame
    chkSlots(0, 0, 31, {1'b0, 16'h8000, 15'b011111111111111}, "f0b");
    chkSlots(1, 0, 0, {1'b1, 31'h0}, "f1c");
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
`default_nettype wire
